// File: rtl/audio_i2s_tx.sv
// Philips I2S master transmitter: one-entry stereo holding buffer, BCLK/LRCK generation, MSB-first serializer.
// Optional macro AUDIO_I2S_TX_UNDERRUN_HOLD_EN repeats the last frame on underrun instead of sending silence.
module audio_i2s_tx #(
  parameter int BITS     = 16,
  parameter int BCLK_DIV = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] in_left,
  input  logic [BITS-1:0] in_right,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            i2s_bclk,
  output logic            i2s_lrck,
  output logic            i2s_dout,
  output logic            underrun
);

  localparam int FW = 2 * BITS;
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] LR_LO    = BW'(BITS - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(FW - 2);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          buf_full;
  logic [FW-1:0] buf_q;
  logic [FW-1:0] shift_q;
  logic [FW-1:0] fill_frame;
  logic          fall_evt;
  logic          frame_start;

`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
  logic [FW-1:0] last_q;
  assign fill_frame = last_q;
`else
  assign fill_frame = '0;
`endif

  // Handshake: a pair transfers on any clk edge where in_valid && in_ready;
  // in_ready depends only on buffer state, and the source holds data while it is low.
  assign in_ready = rst_n & ~buf_full;

  assign fall_evt    = (div_cnt == DIV_LAST) & i2s_bclk;
  assign frame_start = fall_evt & (bit_cnt == BIT_LAST);
  assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
      bit_cnt  <= BIT_LAST;
      i2s_lrck <= 1'b0;
      i2s_dout <= 1'b0;
      buf_full <= 1'b0;
      buf_q    <= '0;
      shift_q  <= '0;
      underrun <= 1'b0;
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
      last_q   <= '0;
`endif
    end else begin
      underrun <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (in_valid && in_ready) begin
        buf_q    <= {in_left, in_right};
        buf_full <= 1'b1;
      end

      if (fall_evt) begin
        bit_cnt  <= bit_nxt;
        // LRCK leads the data by one BCLK, switching during the previous word's LSB.
        i2s_lrck <= (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);
        if (frame_start) begin
          if (buf_full) begin
            i2s_dout <= buf_q[FW-1];
            shift_q  <= {buf_q[FW-2:0], 1'b0};
            buf_full <= 1'b0;
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
            last_q   <= buf_q;
`endif
          end else begin
            i2s_dout <= fill_frame[FW-1];
            shift_q  <= {fill_frame[FW-2:0], 1'b0};
            underrun <= 1'b1;
          end
        end else begin
          i2s_dout <= shift_q[FW-1];
          shift_q  <= {shift_q[FW-2:0], 1'b0};
        end
      end
    end
  end

endmodule
